ezlogic_run_ctrl: RTL and testbench

EZLOGIC_RUN_CTRL -- requirements
Module: ezlogic_run_ctrl

---
 rtl/ezlogic_run_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ezlogic_run_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ezlogic_run_ctrl.sv
// Run controller for an EzLogic core: buffers N input bytes, streams them to the core,
// and compares the core's output bytes against a golden vector with a drain timeout.
module ezlogic_run_ctrl #(
  parameter int              N        = 42,
  parameter logic [8*N-1:0]  EXPECTED = {(8*N){1'b0}},
  parameter int              TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [7:0]                wr_data,
  input  logic                      start,
  output logic                      busy,
  output logic [7:0]                core_data_in,
  output logic                      core_valid_in,
  input  logic [7:0]                core_data_out,
  input  logic                      core_valid_out,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [$clog2(N+1)-1:0]    mismatch_cnt,
  output logic [$clog2(N)-1:0]      first_bad
);

  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;

  logic [7:0]      buf_mem_r [N];
  logic [CW-1:0]   wptr_r;
  logic [CW-1:0]   rptr_r;
  logic [CW-1:0]   ocnt_r;
  logic [CW-1:0]   mis_cnt_r;
  logic [IW-1:0]   first_bad_r;
  logic [TW-1:0]   idle_r;
  logic            busy_r;
  logic            cvi_r;
  logic [7:0]      cdi_r;
  logic            done_r;
  logic            pass_r;
  logic            timeout_r;

  logic            accept_s;
  logic            wr_ok_s;
  logic            active_s;
  logic            cap_s;
  logic            mis_s;
  logic [CW-1:0]   ocnt_nxt_s;
  logic [CW-1:0]   mis_cnt_nxt_s;
  logic [TW-1:0]   idle_nxt_s;
  logic            drain_done_s;
  logic            drain_to_s;

  // Golden byte idx (byte 0 is the MSB byte); out-of-range indices shift to zero.
  function automatic logic [7:0] exp_byte(input logic [CW-1:0] idx);
    logic [8*N-1:0] sh;
    sh = EXPECTED << (8 * int'(idx));
    return sh[8*N-1 -: 8];
  endfunction

  // Run acceptance, capture/compare and drain-exit decode.
  always_comb begin
    accept_s      = (state_r == ST_IDLE) && start && (wptr_r == CW'(N));
    wr_ok_s       = (state_r == ST_IDLE) && !accept_s && wr_en && (wptr_r < CW'(N));
    active_s      = (state_r == ST_STREAM) || (state_r == ST_DRAIN);
    cap_s         = active_s && core_valid_out && (ocnt_r < CW'(N));
    mis_s         = 1'b0;
    ocnt_nxt_s    = ocnt_r;
    mis_cnt_nxt_s = mis_cnt_r;
    idle_nxt_s    = idle_r;
    drain_done_s  = 1'b0;
    drain_to_s    = 1'b0;
    if (cap_s) begin
      mis_s      = (core_data_out != exp_byte(ocnt_r));
      ocnt_nxt_s = ocnt_r + CW'(1);
    end else begin
      mis_s      = 1'b0;
      ocnt_nxt_s = ocnt_r;
    end
    if (mis_s) begin
      mis_cnt_nxt_s = mis_cnt_r + CW'(1);
    end else begin
      mis_cnt_nxt_s = mis_cnt_r;
    end
    if (core_valid_out) begin
      idle_nxt_s = {TW{1'b0}};
    end else begin
      idle_nxt_s = idle_r + TW'(1);
    end
    // Completion wins over a timeout reached in the same cycle.
    if (state_r == ST_DRAIN) begin
      drain_done_s = (ocnt_nxt_s == CW'(N));
      drain_to_s   = !drain_done_s && (idle_nxt_s == TW'(TIMEOUT));
    end else begin
      drain_done_s = 1'b0;
      drain_to_s   = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_STREAM;
        else          next_state_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (rptr_r == CW'(N)) next_state_s = ST_DRAIN;
        else                  next_state_s = ST_STREAM;
      end
      ST_DRAIN: begin
        if (drain_done_s || drain_to_s) next_state_s = ST_DONE;
        else                            next_state_s = ST_DRAIN;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Input byte buffer; contents are don't-care until reloaded.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok_s) buf_mem_r[wptr_r[IW-1:0]] <= wr_data;
  end

  // Pointers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r      <= {CW{1'b0}};
      rptr_r      <= {CW{1'b0}};
      ocnt_r      <= {CW{1'b0}};
      mis_cnt_r   <= {CW{1'b0}};
      first_bad_r <= {IW{1'b0}};
      idle_r      <= {TW{1'b0}};
      busy_r      <= 1'b0;
      cvi_r       <= 1'b0;
      cdi_r       <= 8'h00;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            // Byte 0 is presented straight away so the stream starts the next cycle.
            rptr_r      <= CW'(1);
            ocnt_r      <= {CW{1'b0}};
            mis_cnt_r   <= {CW{1'b0}};
            first_bad_r <= {IW{1'b0}};
            idle_r      <= {TW{1'b0}};
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            busy_r      <= 1'b1;
            cvi_r       <= 1'b1;
            cdi_r       <= buf_mem_r[IW'(0)];
          end else if (wr_ok_s) begin
            wptr_r <= wptr_r + CW'(1);
          end
        end
        ST_STREAM: begin
          if (rptr_r < CW'(N)) begin
            cvi_r  <= 1'b1;
            cdi_r  <= buf_mem_r[rptr_r[IW-1:0]];
            rptr_r <= rptr_r + CW'(1);
          end else begin
            cvi_r <= 1'b0;
            cdi_r <= 8'h00;
          end
          ocnt_r    <= ocnt_nxt_s;
          mis_cnt_r <= mis_cnt_nxt_s;
          if (mis_s && (mis_cnt_r == {CW{1'b0}})) first_bad_r <= ocnt_r[IW-1:0];
        end
        ST_DRAIN: begin
          ocnt_r    <= ocnt_nxt_s;
          mis_cnt_r <= mis_cnt_nxt_s;
          idle_r    <= idle_nxt_s;
          if (mis_s && (mis_cnt_r == {CW{1'b0}})) first_bad_r <= ocnt_r[IW-1:0];
          if (drain_done_s || drain_to_s) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            pass_r    <= drain_done_s && (mis_cnt_nxt_s == {CW{1'b0}});
            timeout_r <= drain_to_s;
            wptr_r    <= {CW{1'b0}};
          end
        end
        ST_DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign core_valid_in = cvi_r;
  assign core_data_in  = cdi_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign timeout       = timeout_r;
  assign mismatch_cnt  = mis_cnt_r;
  assign first_bad     = first_bad_r;

endmodule

// File: tb/tb_ezlogic_run_ctrl.sv
// Directed bench for ezlogic_run_ctrl with a behavioural 1-cycle core model
// (identity, byte-5 corruption, or suppressed final byte).
module tb_ezlogic_run_ctrl;

  localparam logic [335:0] FLAG = "0ops{aadc337c-b5a0-4ff0-ad94-9d1cf41956f4}";

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic [7:0] core_data_in;
  logic       core_valid_in;
  logic [7:0] core_data_out;
  logic       core_valid_out;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [5:0] mismatch_cnt;
  logic [5:0] first_bad;

  logic [335:0] flag_v;
  int tests = 0;
  int fails = 0;
  int mode  = 0;
  int cidx  = 0;
  int r_vcnt, r_first, r_last, r_done, r_bad;

  ezlogic_run_ctrl #(.N(42), .EXPECTED(FLAG), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .busy(busy), .core_data_in(core_data_in), .core_valid_in(core_valid_in),
    .core_data_out(core_data_out), .core_valid_out(core_valid_out),
    .done(done), .pass(pass), .timeout(timeout),
    .mismatch_cnt(mismatch_cnt), .first_bad(first_bad)
  );

  always #5 clk = ~clk;

  // Core model: mode 0 identity, 1 flips bit 0 of byte 5, 2 drops byte 41.
  always @(posedge clk) begin
    if (core_valid_in) cidx <= cidx + 1;
    else               cidx <= 0;
    core_valid_out <= core_valid_in && !(mode == 2 && cidx == 41);
    core_data_out  <= core_data_in ^ ((mode == 1 && cidx == 5) ? 8'h01 : 8'h00);
  end

  function automatic logic [7:0] fbyte(input int k);
    return flag_v[8*(41-k) +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic load(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = fbyte(k);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulse start, then watch the stream until done (bounded); cycle 1 is the cycle after start is sampled.
  task automatic run();
    r_vcnt = 0; r_first = -1; r_last = -1; r_done = -1; r_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (core_valid_in) begin
        if (r_first < 0) r_first = c;
        r_last = c;
        if (r_vcnt >= 42 || core_data_in !== fbyte(r_vcnt)) r_bad++;
        r_vcnt++;
      end
      if (done) begin
        r_done = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    flag_v  = FLAG;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", core_valid_in, 0);
    chk("rst_data", core_data_in, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_miscnt", mismatch_cnt, 0);
    chk("rst_firstbad", first_bad, 0);
    rst_n = 1'b1;

    // Identity core: clean pass.
    mode = 0;
    load(0, 41);
    run();
    chk("id_first_valid", r_first, 1);
    chk("id_valid_count", r_vcnt, 42);
    chk("id_last_valid", r_last, 42);
    chk("id_stream_data", r_bad, 0);
    chk("id_done_within_45", (r_done > 0 && r_done <= 45), 1);
    chk("id_pass", pass, 1);
    chk("id_miscnt", mismatch_cnt, 0);
    chk("id_timeout", timeout, 0);
    chk("id_busy_at_done", busy, 0);
    repeat (3) @(negedge clk);
    chk("id_done_hold", done, 1);
    chk("id_pass_hold", pass, 1);

    // Core corrupts byte 5.
    mode = 1;
    load(0, 41);
    run();
    chk("x5_done", (r_done > 0 && r_done <= 45), 1);
    chk("x5_pass", pass, 0);
    chk("x5_miscnt", mismatch_cnt, 1);
    chk("x5_firstbad", first_bad, 5);
    chk("x5_timeout", timeout, 0);

    // 41 bytes loaded: start must be ignored.
    mode = 0;
    load(0, 40);
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("short_busy", busy, 0);
      chk("short_valid", core_valid_in, 0);
    end
    start = 1'b0;
    load(41, 41);
    run();
    chk("short_valid_count", r_vcnt, 42);
    chk("short_stream_data", r_bad, 0);
    chk("short_pass", pass, 1);

    // Final byte suppressed: DRAIN times out after 64 idle cycles.
    mode = 2;
    load(0, 41);
    run();
    chk("to_done_cycle", r_done, 107);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_miscnt", mismatch_cnt, 0);

    // 43 writes: the extra byte is dropped.
    mode = 0;
    load(0, 41);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_en = 1'b0;
    run();
    chk("ovf_valid_count", r_vcnt, 42);
    chk("ovf_stream_data", r_bad, 0);
    chk("ovf_pass", pass, 1);

    // Reset while byte 20 is on the bus.
    load(0, 41);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_byte20_valid", core_valid_in, 1);
    chk("mid_byte20_data", core_data_in, fbyte(20));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", core_valid_in, 0);
    chk("mid_rst_done", done, 0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_start_ignored", busy, 0);
    end
    start = 1'b0;
    repeat (70) @(negedge clk);
    chk("mid_no_done", done, 0);
    load(0, 41);
    run();
    chk("mid_rerun_count", r_vcnt, 42);
    chk("mid_rerun_pass", pass, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
